// File: rtl/jzjpcc_memory_arbiter.sv
// jzjpcc_memory_arbiter
// Shares one synchronous SRAM port between instruction fetch and the data
// stage. One requester is granted per cycle; data wins contention unless
// fetch has been held off for STARVE_LIMIT consecutive data grants. Read
// data returns one cycle after the grant and is steered by respState.
module jzjpcc_memory_arbiter #(
    parameter int unsigned PC_MAX_B     = 31,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                fetchReq,
    input  logic [PC_MAX_B:2]   fetchAddress,
    output logic                fetchGrant,
    output logic                fetchValid,
    output logic [29:0]         fetchInstruction,

    input  logic                dataReq,
    input  logic                dataWrite,
    input  logic [PC_MAX_B:2]   dataAddress,
    input  logic [3:0]          dataByteEnable,
    input  logic [31:0]         dataWriteData,
    output logic                dataGrant,
    output logic                dataValid,
    output logic [31:0]         dataReadData,

    output logic [PC_MAX_B:2]   memAddress,
    output logic                memWriteEnable,
    output logic [3:0]          memByteEnable,
    output logic [31:0]         memWriteData,
    input  logic [31:0]         memReadData,

    output logic                stall_fetch,
    output logic                stall_decode
);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_FETCH,
        RESP_LOAD,
        RESP_STORE
    } resp_state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    resp_state_t respState;
    resp_state_t respStateNext;
    logic [3:0]  starveCount;
    logic        fetchForced;

    // Grant selection: data has priority unless fetch has starved long enough
    always_comb begin
        fetchForced = (starveCount == STARVE_MAX);
        fetchGrant  = 1'b0;
        dataGrant   = 1'b0;
        if (dataReq && fetchReq) begin
            fetchGrant = fetchForced;
            dataGrant  = ~fetchForced;
        end else if (dataReq) begin
            dataGrant  = 1'b1;
        end else if (fetchReq) begin
            fetchGrant = 1'b1;
        end
    end

    // SRAM port steering; the write strobe is held off while reset is low
    always_comb begin
        memAddress     = dataGrant ? dataAddress : fetchAddress;
        memWriteEnable = dataGrant & dataWrite & reset;
        memByteEnable  = (dataGrant && dataWrite) ? dataByteEnable : 4'b0000;
        memWriteData   = dataWriteData;
        stall_fetch    = fetchReq & ~fetchGrant;
        stall_decode   = fetchReq & ~fetchGrant;
    end

    // Count consecutive data grants taken while fetch is waiting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starveCount <= '0;
        end else if (fetchGrant || !fetchReq) begin
            starveCount <= '0;
        end else if (dataGrant && (starveCount != STARVE_MAX)) begin
            starveCount <= starveCount + 4'd1;
        end
    end

    // Response state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            respState <= RESP_NONE;
        end else begin
            respState <= respStateNext;
        end
    end

    // Next response is determined entirely by this cycle's grant
    always_comb begin
        respStateNext = RESP_NONE;
        if (fetchGrant) begin
            respStateNext = RESP_FETCH;
        end else if (dataGrant) begin
            respStateNext = dataWrite ? RESP_STORE : RESP_LOAD;
        end
    end

    // Response outputs decoded from the pending response
    always_comb begin
        fetchValid       = (respState == RESP_FETCH);
        dataValid        = (respState == RESP_LOAD) || (respState == RESP_STORE);
        fetchInstruction = memReadData[31:2];
        dataReadData     = memReadData;
    end

endmodule

// File: doc/jzjpcc_memory_arbiter.md
Name: jzjpcc_memory_arbiter

Overview:
Shares the core's single synchronous SRAM port between instruction fetch and the data (load/store) stage. Grants one requester per cycle and drives the SRAM address, write enable and write data. Routes the 1-cycle-latency read data back to the granted requester. Generates the fetch/decode stall lines consumed by the fetch stage's hazard inputs.

Parameters:
PC_MAX_B, 31, MSB of the word address; addresses are [PC_MAX_B:2].
STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits before fetch is forced; range 1..15.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
fetchReq  input  1  fetch wants a word this cycle
fetchAddress  input  PC_MAX_B-1  fetch word address [PC_MAX_B:2]
fetchGrant  output  1  fetch owns the SRAM port this cycle (combinational)
fetchValid  output  1  fetchInstruction valid (cycle after fetchGrant)
fetchInstruction  output  30  memReadData[31:2]
dataReq  input  1  load/store request
dataWrite  input  1  1 = store, 0 = load
dataAddress  input  PC_MAX_B-1  data word address
dataByteEnable  input  4  store byte lanes
dataWriteData  input  32  store data
dataGrant  output  1  data owns the port this cycle (combinational)
dataValid  output  1  load data valid / store acknowledged
dataReadData  output  32  load result
memAddress  output  PC_MAX_B-1  SRAM address, latched by the SRAM at posedge
memWriteEnable  output  1  SRAM write strobe
memByteEnable  output  4  SRAM byte lanes
memWriteData  output  32  SRAM write data
memReadData  input  32  SRAM read data, valid the cycle after the address was presented
stall_fetch  output  1  fetchReq & ~fetchGrant
stall_decode  output  1  equals stall_fetch

Behaviour:
- Grant (combinational each cycle):
  - Only dataReq: data. Only fetchReq: fetch. Neither: no grant.
  - Both: data, unless starveCount == STARVE_LIMIT, then fetch.
- Mux:
  - memAddress = dataAddress when dataGrant, else fetchAddress, including when idle.
  - memWriteEnable = dataGrant & dataWrite.
  - memByteEnable = dataByteEnable when a store is granted, else 4'b0000.
  - memWriteData = dataWriteData at all times.
- starveCount: 4-bit register, reset 0.
  - Increments when dataGrant & fetchReq, saturating at STARVE_LIMIT.
  - Clears when fetchGrant or ~fetchReq.
- Response FSM, register respState:
  - States: RESP_NONE, RESP_FETCH, RESP_LOAD, RESP_STORE.
  - Next state: fetchGrant -> RESP_FETCH; dataGrant & ~dataWrite -> RESP_LOAD; dataGrant & dataWrite -> RESP_STORE; no grant -> RESP_NONE.
- Response outputs (combinational from respState):
  - fetchValid = (respState == RESP_FETCH).
  - dataValid = (respState == RESP_LOAD | respState == RESP_STORE).
  - fetchInstruction = memReadData[31:2] and dataReadData = memReadData at all times; they are meaningful only while the matching valid is high.
- Latency: grant in cycle N -> valid in cycle N+1. Back-to-back grants deliver one response per cycle with no bubble.
- Handshake:
  - Requester holds req, address and write fields stable until it sees its grant.
  - It may drop req or change the request on the cycle after the grant.
  - A grant is never revoked once issued.
- Reset (reset == 0, asynchronous):
  - respState = RESP_NONE and starveCount = 0, so fetchValid = dataValid = 0.
  - Grants and stalls keep following inputs combinationally; memWriteEnable is forced 0 while reset is low.
- Reset mid-operation: a response pending when reset asserts is discarded and no valid appears after release. Release must not create a spurious write.
- Same-address case: store granted in cycle N, fetch of that address granted in N+1 -> fetchInstruction in N+2 returns the stored word. This is guaranteed by the sequential grants, not by SRAM read-during-write behaviour.
- Starvation bound: with both requests held continuously, fetch is granted at least once every STARVE_LIMIT+1 cycles.

Test Plan:
- Fetch only: fetchReq=1 at addresses 0,1,2 on consecutive cycles, SRAM preloaded -> fetchGrant=1 each cycle; fetchValid=1 one cycle later with the matching words; stall_fetch=0 throughout.
- Store then fetch same address: store 32'h00500093 to word 0x10 with byte enables 4'b1111 in cycle N, then fetch 0x10 -> memWriteEnable=1 only in N; dataValid=1 in N+1; fetchInstruction=32'h00500093[31:2] in N+2.
- Contention: dataReq and fetchReq both held 10 cycles with STARVE_LIMIT=4 -> grant pattern D,D,D,D,F,D,D,D,D,F; stall_fetch=1 on every D cycle; starveCount returns to 0 after each F.
- Byte-lane store: byte enables 4'b0010 with data 32'hAABBCCDD -> memByteEnable=4'b0010 for that cycle only; a later load of the same word returns 0xCC in bits [15:8] and the other bytes unchanged.
- Reset mid-load: load granted in cycle N, reset driven low before edge N+1, released at N+3 -> dataValid stays 0 throughout; respState=RESP_NONE and starveCount=0 after release; no memWriteEnable pulse.
- Idle: both requests low -> no grants, no valids, memWriteEnable=0, memAddress follows fetchAddress.
